// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the buffered UART transmitter
// Purpose: parity mode codes, transmitter state encoding, default bit period and
//          the parity-bit helper used by fifo_uart_tx.
// Ports:   none (package).
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // 100 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // acc is the XOR of all data bits; odd parity inverts it so that the total
  // number of ones including the parity bit comes out odd.
  function automatic logic parity_bit(input logic acc, input int mode);
    if (mode == PAR_ODD)  return ~acc;
    if (mode == PAR_EVEN) return acc;
    return 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty/count
// Purpose: circular buffer of DEPTH entries (power of two) with a combinational
//          head read; pushes when full and pops when empty are ignored.
// Ports:   clk, rst (async, active high), push/din (write), pop (consume head),
//          dout (current head), full, empty, count (occupancy 0..DEPTH).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // pointers are AW bits wide, so they wrap modulo DEPTH by themselves
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // flags derived from the next count so all three stay consistent
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // storage needs no reset: entries are only read once counted as valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-buffered UART transmitter with configurable framing
// Purpose: queues characters written with a one-cycle strobe and serialises
//          them as start / DATA_BITS (LSB first) / optional parity / stop bits.
// Ports:   clk, rst (async, active high), din/wen (enqueue), tx_out (serial
//          line, idle high), busy (frame in progress), full, empty, count
//          (FIFO occupancy), overflow (one-cycle pulse on a dropped write).
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 16,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_BITS-1:0]   din,
  input  logic                   wen,
  output logic                   tx_out,
  output logic                   busy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 acc_q, acc_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;

  logic                 bit_end;
  logic                 load;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full, fifo_empty;

  // full is the registered flag, so a write in the same cycle as a pop from a
  // full FIFO is still dropped
  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wen),
    .din   (din),
    .pop   (load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    tx_d      = tx_q;
    load      = 1'b0;
    bit_end   = (timer_q == TIMER_LAST);

    if (state_q != ST_IDLE) timer_d = bit_end ? '0 : timer_q + 1'b1;

    // tx_d is the level of the cycle that follows this edge, so the line is
    // a pure register output
    case (state_q)
      ST_IDLE: begin
        tx_d    = 1'b1;
        timer_d = '0;
        load    = !fifo_empty;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          acc_d   = acc_q ^ shreg_q[0];
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = parity_bit(acc_q ^ shreg_q[0], PARITY);
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_idx_d = '0;
          tx_d      = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // shared frame start from IDLE or straight out of the last stop bit
    if (load) begin
      state_d   = ST_START;
      shreg_d   = fifo_dout;
      acc_d     = 1'b0;
      tx_d      = 1'b0;
      timer_d   = '0;
      bit_idx_d = '0;
    end

    busy_d     = (state_d != ST_IDLE);
    overflow_d = wen && fifo_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      acc_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_out   = tx_q;
  assign busy     = busy_q;
  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx in three framings
module tb_fifo_uart_tx;

  logic clk;
  int   checks   = 0;
  int   failures = 0;
  bit   done [3];

  function automatic void chk1(input int g, input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s: got %b expected %b", g, name, act, exp);
    end
  endfunction

  function automatic void chkn(input int g, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL cfg%0d %s: got %0d expected %0d", g, name, act, exp);
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cfg0: 8N1, 4 clk/bit, depth 4 | cfg1: 8E1, 4 clk/bit, depth 16 | cfg2: 7O2, 3 clk/bit, depth 8
  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int CPB  = (g == 2) ? 3 : 4;
    localparam int DB   = (g == 2) ? 7 : 8;
    localparam int DP   = (g == 0) ? 4 : (g == 1) ? 16 : 8;
    localparam int PAR  = (g == 1) ? 2 : (g == 2) ? 1 : 0;
    localparam int STOP = (g == 2) ? 2 : 1;
    // hand-computed frame lengths and line patterns (bit k = k-th bit slot)
    // cfg0 0x55: 0,1,0,1,0,1,0,1,0,1 ; cfg1 0x07 8E1 and cfg2 0x07 7O2 both give
    // 0,1,1,1,0,0,0,0,0,1,1
    localparam int FL          = (g == 0) ? 40 : (g == 1) ? 44 : 33;
    localparam int FIRST_CHAR  = (g == 0) ? 'h55 : 'h07;
    localparam logic [10:0] PATTERN = (g == 0) ? 11'h2AA : 11'h60E;

    logic                 rst;
    logic [DB-1:0]        din;
    logic                 wen;
    logic                 tx_out, busy, full, empty, overflow;
    logic [$clog2(DP):0]  count;

    fifo_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB),
      .DEPTH        (DP),
      .PARITY       (PAR),
      .STOP_BITS    (STOP)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .wen      (wen),
      .tx_out   (tx_out),
      .busy     (busy),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
    );

    // Model: mq = queued characters, wave = line level for every remaining
    // cycle of the frame in flight (wave[0] is the level shown now).
    int  mq [$];
    bit  wave [$];
    bit  m_ovf;
    bit  armed;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mq.delete();
        wave.delete();
        m_ovf = 1'b0;
      end else begin
        int pre;
        int d;
        int ones;
        bit p;
        pre   = mq.size();
        m_ovf = wen && (pre == DP);
        if (wave.size() > 0) void'(wave.pop_front());
        if (wave.size() == 0 && pre > 0) begin
          d = mq.pop_front();
          repeat (CPB) wave.push_back(1'b0);
          for (int i = 0; i < DB; i++) repeat (CPB) wave.push_back(d[i]);
          if (PAR != 0) begin
            ones = $countones(d);
            p    = (PAR == 1) ? ~ones[0] : ones[0];
            repeat (CPB) wave.push_back(p);
          end
          repeat (STOP * CPB) wave.push_back(1'b1);
        end
        if (wen && pre < DP) mq.push_back(int'(din));
      end
    end

    always @(negedge clk) begin
      if (armed && !rst) begin
        chk1(g, "tx_out",   tx_out,   (wave.size() > 0) ? wave[0] : 1'b1);
        chk1(g, "busy",     busy,     wave.size() > 0);
        chkn(g, "count",    int'(count), mq.size());
        chk1(g, "full",     full,     mq.size() == DP);
        chk1(g, "empty",    empty,    mq.size() == 0);
        chk1(g, "overflow", overflow, m_ovf);
      end
    end

    task automatic drain();
      int n;
      n = 0;
      while ((busy || !empty) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      chk1(g, "drain_idle", busy, 1'b0);
    endtask

    initial begin
      int          n;
      int          ovf_n;
      int          busy_n;
      int          cv;
      bit          smp [$];
      logic [10:0] pat;
      int          rate_tab [4];
      rate_tab = '{5, 30, 90, 60};
      pat      = PATTERN;
      cv       = FIRST_CHAR;
      rst = 1'b1; wen = 1'b0; din = '0; armed = 1'b0;
      repeat (3) @(negedge clk);
      chk1(g, "rst_tx_out", tx_out, 1'b1);
      chk1(g, "rst_busy", busy, 1'b0);
      chk1(g, "rst_full", full, 1'b0);
      chk1(g, "rst_empty", empty, 1'b1);
      chkn(g, "rst_count", int'(count), 0);
      chk1(g, "rst_overflow", overflow, 1'b0);
      rst = 1'b0; armed = 1'b1;

      // single frame: latency, exact length and line pattern
      @(negedge clk);
      wen = 1'b1; din = DB'(cv);
      @(negedge clk);
      wen = 1'b0;
      chk1(g, "lat1_tx_out", tx_out, 1'b1);
      chk1(g, "lat1_empty", empty, 1'b0);
      @(negedge clk);
      chk1(g, "lat2_tx_out", tx_out, 1'b0);
      chk1(g, "lat2_busy", busy, 1'b1);
      n = 0;
      smp.delete();
      while (busy && n < 400) begin
        smp.push_back(tx_out);
        n++;
        @(negedge clk);
      end
      chkn(g, "frame_len", n, FL);
      chk1(g, "frame_end_empty", empty, 1'b1);
      for (int k = 0; k < FL / CPB; k++)
        chk1(g, "frame_bit", (k * CPB + CPB / 2 < smp.size()) ? smp[k * CPB + CPB / 2] : 1'bx, pat[k]);

      // burst of DEPTH+2 writes: one drop, then DEPTH+1 frames back to back
      ovf_n = 0; busy_n = 0;
      for (int i = 0; i < DP + 2; i++) begin
        wen = 1'b1; din = DB'($urandom);
        @(negedge clk);
        if (overflow) ovf_n++;
        if (busy) busy_n++;
        if (i == DP) chk1(g, "burst_full", full, 1'b1);
      end
      wen = 1'b0;
      n = 0;
      while (n < 20000) begin
        @(negedge clk);
        if (!busy) break;
        busy_n++;
        n++;
      end
      chkn(g, "burst_ovf_pulses", ovf_n, 1);
      chkn(g, "burst_busy_cycles", busy_n, (DP + 1) * FL);
      drain();

      // push on the same edge the next character is popped
      for (int i = 0; i < 3; i++) begin
        wen = 1'b1; din = DB'($urandom);
        @(negedge clk);
      end
      wen = 1'b0;
      n = 0;
      while (wave.size() != 1 && n < 500) begin
        @(negedge clk);
        n++;
      end
      chkn(g, "pushpop_pre_count", int'(count), 2);
      wen = 1'b1; din = DB'($urandom);
      @(negedge clk);
      wen = 1'b0;
      chkn(g, "pushpop_count", int'(count), 2);
      chk1(g, "pushpop_overflow", overflow, 1'b0);
      drain();

      // random traffic at several write rates
      for (int c = 0; c < 1200; c++) begin
        wen = ($urandom_range(99) < rate_tab[c / 300]);
        din = DB'($urandom);
        @(negedge clk);
      end
      wen = 1'b0;
      drain();

      // reset in the middle of a data bit with three characters queued
      for (int i = 0; i < 4; i++) begin
        wen = 1'b1; din = DB'($urandom);
        @(negedge clk);
      end
      wen = 1'b0;
      repeat (CPB + 1) @(negedge clk);
      chkn(g, "pre_reset_count", int'(count), 3);
      #2 rst = 1'b1;
      #1;
      chk1(g, "midrst_tx_out", tx_out, 1'b1);
      chk1(g, "midrst_busy", busy, 1'b0);
      chk1(g, "midrst_empty", empty, 1'b1);
      chkn(g, "midrst_count", int'(count), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wen = 1'b1; din = DB'($urandom);
      @(negedge clk);
      wen = 1'b0;
      drain();
      done[g] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60000) chkn(-1, "global_timeout", n, 0);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
